// File: rtl/t01_button_debounce_pkg.sv
// Shared types and default timing constants for the button debouncer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package t01_button_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } t01_btn_state_t;

    localparam int T01_DEBOUNCE_CYCLES_DEF = 10000;
    localparam int T01_HOLD_CYCLES_DEF     = 500000;
    localparam int T01_REPEAT_CYCLES_DEF   = 100000;

    // Counter width: enough for the largest parameter plus one spare bit, so
    // the repeat window (HOLD-1 .. HOLD-1+REPEAT) never wraps.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/t01_button_debounce_if.sv
// Bundles the synchronized button input with the debounced level and event pulses.
// Latency: n/a (wiring only).
// Backpressure: none; pulses are fire-and-forget single-cycle events.
interface t01_button_debounce_if;
    logic button_sync;
    logic button_level;
    logic press_pulse;
    logic release_pulse;
    logic repeat_pulse;
    logic long_press;

    // Debouncer side: consumes the raw level, produces level and events.
    modport master (
        input  button_sync,
        output button_level,
        output press_pulse,
        output release_pulse,
        output repeat_pulse,
        output long_press
    );

    // Consumer side: supplies the raw level, observes level and events.
    modport slave (
        output button_sync,
        input  button_level,
        input  press_pulse,
        input  release_pulse,
        input  repeat_pulse,
        input  long_press
    );
endinterface

// File: rtl/t01_button_debounce.sv
// Debounces a synchronized button level; emits press/release/repeat pulses and a long-press flag.
// Latency: level change accepted after DEBOUNCE_CYCLES stable edges; all outputs registered.
// Backpressure: none; pulses are single-cycle and cannot be stalled.
module t01_button_debounce
    import t01_button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = T01_DEBOUNCE_CYCLES_DEF,
    parameter int HOLD_CYCLES     = T01_HOLD_CYCLES_DEF,
    parameter int REPEAT_CYCLES   = T01_REPEAT_CYCLES_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    t01_button_debounce_if.master   btn
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES);

    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    // After the first repeat the hold counter loops back to HOLD_LAST each
    // period, so it stays bounded however long the button is held.
    localparam logic [CW-1:0] REP_LAST  = CW'(HOLD_CYCLES - 1 + REPEAT_CYCLES);

    t01_btn_state_t state, state_nxt;
    logic [CW-1:0]  db_cnt, db_nxt;
    logic [CW-1:0]  hold_cnt, hold_nxt;
    logic [CW-1:0]  hold_inc;
    logic           level_q, level_nxt;
    logic           press_q, press_nxt;
    logic           release_q, release_nxt;
    logic           repeat_q, repeat_nxt;
    logic           long_q, long_nxt;
    logic           hold_adv;

    assign hold_inc = hold_cnt + 1'b1;

    // State register; reset aborts any in-flight debounce immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state, counters and registered-output values.
    always_comb begin
        state_nxt   = state;
        db_nxt      = db_cnt;
        hold_nxt    = hold_cnt;
        level_nxt   = level_q;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        repeat_nxt  = 1'b0;
        long_nxt    = long_q;
        hold_adv    = 1'b0;

        case (state)
            IDLE: begin
                level_nxt = 1'b0;
                if (btn.button_sync) begin
                    state_nxt = PRESS_WAIT;
                    db_nxt    = CW'(1);
                end
            end
            PRESS_WAIT: begin
                if (!btn.button_sync) begin
                    state_nxt = IDLE;
                    db_nxt    = '0;
                end else if (db_cnt == DB_LAST) begin
                    state_nxt = HELD;
                    db_nxt    = '0;
                    level_nxt = 1'b1;
                    press_nxt = 1'b1;
                end else begin
                    db_nxt = db_cnt + 1'b1;
                end
            end
            HELD: begin
                if (!btn.button_sync) begin
                    state_nxt = RELEASE_WAIT;
                    db_nxt    = CW'(1);
                end else begin
                    hold_adv = 1'b1;
                end
            end
            RELEASE_WAIT: begin
                if (btn.button_sync) begin
                    // Release was a glitch: resume holding from the frozen count.
                    state_nxt = HELD;
                    db_nxt    = '0;
                    hold_adv  = 1'b1;
                end else if (db_cnt == DB_LAST) begin
                    state_nxt   = IDLE;
                    db_nxt      = '0;
                    hold_nxt    = '0;
                    level_nxt   = 1'b0;
                    release_nxt = 1'b1;
                    long_nxt    = 1'b0;
                end else begin
                    db_nxt = db_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (hold_adv) begin
            hold_nxt = hold_inc;
            if (hold_inc == HOLD_LAST) begin
                repeat_nxt = 1'b1;
                long_nxt   = 1'b1;
            end else if (long_q && hold_inc == REP_LAST) begin
                repeat_nxt = 1'b1;
                hold_nxt   = HOLD_LAST;
            end
        end
    end

    // Counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_cnt    <= '0;
            hold_cnt  <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            db_cnt    <= db_nxt;
            hold_cnt  <= hold_nxt;
            level_q   <= level_nxt;
            press_q   <= press_nxt;
            release_q <= release_nxt;
            repeat_q  <= repeat_nxt;
            long_q    <= long_nxt;
        end
    end

    assign btn.button_level  = level_q;
    assign btn.press_pulse   = press_q;
    assign btn.release_pulse = release_q;
    assign btn.repeat_pulse  = repeat_q;
    assign btn.long_press    = long_q;

endmodule

// File: tb/tb_t01_button_debounce.sv
// Directed plus randomized bench for the debouncer against a run-length reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_t01_button_debounce;
    import t01_button_pkg::*;

    localparam int D = 4;
    localparam int H = 20;
    localparam int R = 8;

    logic clk;
    logic rst;

    t01_button_debounce_if btn();

    t01_button_debounce #(
        .DEBOUNCE_CYCLES (D),
        .HOLD_CYCLES     (H),
        .REPEAT_CYCLES   (R)
    ) dut (
        .clk (clk),
        .rst (rst),
        .btn (btn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: debounced level flips once the input has disagreed
    // with it for D consecutive edges; while pressed, each edge with the
    // input high advances the hold time, and repeats fire at H-1 and every
    // R after that.
    bit m_level, m_press, m_rel, m_rep, m_long;
    int m_run, m_held;
    int rep_seen;

    function automatic void model_reset();
        m_level = 0; m_press = 0; m_rel = 0; m_rep = 0; m_long = 0;
        m_run = 0; m_held = 0;
    endfunction

    function automatic void model_step(input bit b);
        m_press = 0; m_rel = 0; m_rep = 0;
        if (b != m_level) m_run++;
        else              m_run = 0;
        if (m_run == D) begin
            m_level = !m_level;
            m_run   = 0;
            m_held  = 0;
            if (m_level) m_press = 1;
            else begin
                m_rel  = 1;
                m_long = 0;
            end
        end else if (m_level && b) begin
            m_held++;
            if (m_held == H - 1 || (m_held > H - 1 && (m_held - (H - 1)) % R == 0)) begin
                m_rep  = 1;
                m_long = 1;
            end
        end
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".level"},   btn.button_level,  m_level);
        check({tag, ".press"},   btn.press_pulse,   m_press);
        check({tag, ".release"}, btn.release_pulse, m_rel);
        check({tag, ".repeat"},  btn.repeat_pulse,  m_rep);
        check({tag, ".long"},    btn.long_press,    m_long);
        check({tag, ".excl"},
              ($countones({btn.press_pulse, btn.release_pulse, btn.repeat_pulse}) <= 1), 1'b1);
    endtask

    // One clock: drive input, let the edge happen, advance the model, compare at negedge.
    task automatic cycle(input string tag, input bit b);
        btn.button_sync = b;
        @(posedge clk);
        model_step(b);
        @(negedge clk);
        check_all(tag);
        if (btn.repeat_pulse === 1'b1) rep_seen++;
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".level"},   btn.button_level,  1'b0);
        check({tag, ".press"},   btn.press_pulse,   1'b0);
        check({tag, ".release"}, btn.release_pulse, 1'b0);
        check({tag, ".repeat"},  btn.repeat_pulse,  1'b0);
        check({tag, ".long"},    btn.long_press,    1'b0);
    endtask

    initial begin
        int press_edge;
        int len;
        bit v;

        model_reset();
        rst = 1'b1;
        btn.button_sync = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // 1. Stable press: accepted on the D-th edge only.
        for (int i = 0; i < D + 1; i++) begin
            cycle("press", 1'b1);
            if (i == D - 2) check("press.early", btn.button_level, 1'b0);
            if (i == D - 1) check("press.edge3", btn.press_pulse, 1'b1);
            if (i == D)     check("press.edge4", btn.press_pulse, 1'b0);
        end
        // Release cleanly back to idle before the bounce test.
        for (int i = 0; i < D + 1; i++) cycle("rel0", 1'b0);
        check("rel0.level", btn.button_level, 1'b0);

        // 2. Bounce shorter than D never gets through.
        for (int i = 0; i < 30; i++) cycle("bounce", (i % 3) != 2);
        check("bounce.level", btn.button_level, 1'b0);
        for (int i = 0; i < D; i++) cycle("bounce_clr", 1'b0);

        // 3. Accept a press, then hold 40 cycles: exactly three repeats.
        for (int i = 0; i < D; i++) cycle("acc", 1'b1);
        check("acc.press", btn.press_pulse, 1'b1);
        rep_seen = 0;
        for (int i = 1; i <= 40; i++) begin
            cycle("hold", 1'b1);
            if (i == 19) check("hold.rep19", btn.repeat_pulse, 1'b1);
            if (i == 18) check("hold.long18", btn.long_press, 1'b0);
        end
        check_int("hold.count", rep_seen, 3);
        check("hold.long", btn.long_press, 1'b1);

        // 4. Release glitch of 3 cycles: no release, repeats shift by 3.
        for (int i = 0; i < 3; i++) cycle("glitch", 1'b0);
        check("glitch.level", btn.button_level, 1'b1);
        rep_seen = 0;
        // Last repeat at hold 35 before the glitch; next expected at 43 -> 3 + 3 edges late.
        for (int i = 1; i <= 6; i++) begin
            cycle("resume", 1'b1);
            if (i == 5) check("resume.rep_shift", btn.repeat_pulse, 1'b0);
        end
        check_int("resume.count", rep_seen, 1);

        // 5. Clean release: pulse on the D-th zero edge, level and long drop together.
        for (int i = 0; i < D; i++) cycle("release", 1'b0);
        check("release.pulse", btn.release_pulse, 1'b1);
        check("release.level", btn.button_level, 1'b0);
        check("release.long",  btn.long_press, 1'b0);
        cycle("release_after", 1'b0);

        // 6a. Async reset while long-pressed: outputs clear without a clock edge.
        for (int i = 0; i < D + H + 2; i++) cycle("pre_rst", 1'b1);
        check("pre_rst.long", btn.long_press, 1'b1);
        #2 rst = 1'b1;
        #1 check_zero("arst_held");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < D; i++) cycle("arst_clr", 1'b0);

        // 6b. Async reset mid press-debounce; full debounce again afterwards.
        cycle("pw", 1'b1);
        cycle("pw", 1'b1);
        #2 rst = 1'b1;
        #1 check_zero("arst_pw");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        press_edge = -1;
        for (int i = 1; i <= D + 2; i++) begin
            cycle("post_rst", 1'b1);
            if (btn.press_pulse === 1'b1 && press_edge < 0) press_edge = i;
        end
        check_int("post_rst.edge", press_edge, D);

        // Randomized bounce/hold runs against the model.
        for (int i = 0; i < 4; i++) cycle("rnd_clr", 1'b0);
        v = 1'b1;
        for (int k = 0; k < 120; k++) begin
            len = (k % 5 == 4) ? int'($urandom_range(20, 40)) : int'($urandom_range(1, 7));
            for (int j = 0; j < len; j++) cycle("rnd", v);
            v = !v;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
